// File: rtl/mc_control.sv
// mc_control: Moore-style multi-cycle sequencer for a MIPS multi-cycle datapath.
// Runs one instruction at a time through FETCH/DECODE/execute/write-back
// states and drives the datapath enables, mux selects and ALU function code.
// It counts retired instructions and parks in a sticky ERR state on an
// unsupported opcode or an ALU fault.
//
// Optional feature macro: MC_CONTROL_MEM_READY_EN
//   When defined, adds input mem_ready. FETCH, MEM_RD and MEM_WR hold their
//   state until mem_ready=1.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   op, func          IR[31:26] and IR[5:0]
//   alu_cond, alu_err ALU condition flag and ALU fault flag
//   mem_ready         (macro only) memory handshake, 1 = access complete
//   ir_write, pc_write, pc_cond, pc_inc, mem_write, reg_write  write enables
//   alu_src_a, alu_src_b, alu_op, pc_source, mdr_src, reg_dst, mem_to_reg
//                     datapath mux selects and ALU function code
//   state             current FSM state, for debug
//   error             sticky fault (state == ERR)
//   retired           completed-instruction count, wraps silently
//
// Handshake: with the macro, a memory state advances on a clock edge where
// mem_ready=1 and holds (outputs unchanged) on every edge where it is 0.
module mc_control #(
  parameter int         CNT_W  = 32,
  parameter logic [5:0] ADD_FN = 6'h20,
  parameter logic [5:0] SUB_FN = 6'h22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             alu_cond,
  input  logic             alu_err,
`ifdef MC_CONTROL_MEM_READY_EN
  input  logic             mem_ready,
`endif
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_cond,
  output logic             pc_inc,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [5:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             mem_write,
  output logic             mdr_src,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic [3:0]       state,
  output logic             error,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEM_ADDR = 4'd2;
  localparam logic [3:0] MEM_RD   = 4'd3;
  localparam logic [3:0] MEM_WB   = 4'd4;
  localparam logic [3:0] MEM_WR   = 4'd5;
  localparam logic [3:0] R_EXE    = 4'd6;
  localparam logic [3:0] R_WB     = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] JUMP     = 4'd9;
  localparam logic [3:0] ADDI_EXE = 4'd10;
  localparam logic [3:0] ADDI_WB  = 4'd11;
  localparam logic [3:0] JAL      = 4'd12;
  localparam logic [3:0] ERR      = 4'd15;

  logic [3:0] next_state;
  logic       mem_go;
  logic       retire;

  // alu_cond is combined with pc_cond outside this block.
  logic unused_alu_cond;
  assign unused_alu_cond = alu_cond;

`ifdef MC_CONTROL_MEM_READY_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  always_comb begin
    next_state = state;
    case (state)
      FETCH:    if (mem_go) next_state = DECODE;
      DECODE: begin
        case (op)
          6'h00:        next_state = R_EXE;
          6'h23, 6'h2B: next_state = MEM_ADDR;
          6'h04:        next_state = BRANCH;
          6'h02:        next_state = JUMP;
          6'h03:        next_state = JAL;
          6'h08:        next_state = ADDI_EXE;
          default:      next_state = ERR;
        endcase
      end
      MEM_ADDR: next_state = alu_err ? ERR : ((op == 6'h23) ? MEM_RD : MEM_WR);
      MEM_RD:   if (mem_go) next_state = MEM_WB;
      MEM_WB:   next_state = FETCH;
      MEM_WR:   if (mem_go) next_state = FETCH;
      R_EXE:    next_state = alu_err ? ERR : R_WB;
      R_WB:     next_state = FETCH;
      BRANCH:   next_state = alu_err ? ERR : FETCH;
      JUMP:     next_state = FETCH;
      JAL:      next_state = FETCH;
      ADDI_EXE: next_state = alu_err ? ERR : ADDI_WB;
      ADDI_WB:  next_state = FETCH;
      default:  next_state = ERR;
    endcase
  end

  // Every path back to FETCH from a non-FETCH state completes an instruction;
  // a held FETCH and a faulting BRANCH are excluded by construction.
  assign retire = (state != FETCH) && (next_state == FETCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      retired <= '0;
    end else begin
      state <= next_state;
      if (retire) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_cond    = 1'b0;
    pc_inc     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 6'd0;
    pc_source  = 2'd0;
    mem_write  = 1'b0;
    mdr_src    = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    case (state)
      FETCH: begin
        ir_write = 1'b1;
        pc_inc   = 1'b1;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        alu_op    = ADD_FN;
      end
      MEM_ADDR, ADDI_EXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = ADD_FN;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
      end
      MEM_WR: mem_write = 1'b1;
      R_EXE: begin
        alu_src_a = 1'b1;
        alu_op    = func;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'd1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = SUB_FN;
        pc_cond   = 1'b1;
        pc_source = 2'd1;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
      end
      JAL: begin
        pc_write   = 1'b1;
        pc_source  = 2'd2;
        mdr_src    = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd1;
      end
      ADDI_WB: reg_write = 1'b1;
      default: ;
    endcase
    // A write in flight when reset rises is abandoned in that same cycle.
    if (reset) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_cond   = 1'b0;
      pc_inc    = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign error = (state == ERR);

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op;
  logic [5:0]  func;
  logic        alu_cond;
  logic        alu_err;
`ifdef MC_CONTROL_MEM_READY_EN
  logic        mem_ready;
`endif
  logic        ir_write, pc_write, pc_cond, pc_inc, alu_src_a;
  logic [1:0]  alu_src_b, pc_source, reg_dst, mem_to_reg;
  logic [5:0]  alu_op;
  logic        mem_write, mdr_src, reg_write, error;
  logic [3:0]  state;
  logic [31:0] retired;

  int n_cmp = 0;
  int n_bad = 0;

  mc_control dut (
    .clk(clk), .reset(reset), .op(op), .func(func),
    .alu_cond(alu_cond), .alu_err(alu_err),
`ifdef MC_CONTROL_MEM_READY_EN
    .mem_ready(mem_ready),
`endif
    .ir_write(ir_write), .pc_write(pc_write), .pc_cond(pc_cond),
    .pc_inc(pc_inc), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .mem_write(mem_write),
    .mdr_src(mdr_src), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .state(state), .error(error),
    .retired(retired)
  );

  // clock / reset
  always #5 clk = ~clk;

  // one cycle; outputs are sampled 1 ns after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // walk DECODE..last state of an instruction, checking the state sequence
  task automatic expect_states(input string tag, input logic [3:0] s1,
                               input logic [3:0] s2, input logic [3:0] s3,
                               input int n);
    logic [3:0] seq [3];
    seq[0] = s1; seq[1] = s2; seq[2] = s3;
    for (int i = 0; i < n; i++) begin
      tick();
      check_eq({tag, "_state"}, state, seq[i]);
    end
  endtask

  initial begin
    reset = 1'b1; op = 6'h00; func = 6'h20; alu_cond = 1'b0; alu_err = 1'b0;
`ifdef MC_CONTROL_MEM_READY_EN
    mem_ready = 1'b1;
`endif
    tick(); tick();
    check_eq("rst_state", state, 0);
    check_eq("rst_retired", retired, 0);
    check_eq("rst_ir_write_gated", ir_write, 0);
    reset = 1'b0;
    #1;
    check_eq("fetch_ir_write", ir_write, 1);
    check_eq("fetch_pc_inc", pc_inc, 1);
    check_eq("fetch_error", error, 0);

    // R-type add: 0,1,6,7,0
    op = 6'h00; func = 6'h20;
    tick();
    check_eq("dec_state", state, 1);
    check_eq("dec_src_b", alu_src_b, 3);
    check_eq("dec_alu_op", alu_op, 6'h20);
    tick();
    check_eq("rexe_state", state, 6);
    check_eq("rexe_alu_op", alu_op, 6'h20);
    check_eq("rexe_src_a", alu_src_a, 1);
    tick();
    check_eq("rwb_state", state, 7);
    check_eq("rwb_reg_write", reg_write, 1);
    check_eq("rwb_reg_dst", reg_dst, 1);
    check_eq("rwb_retired_pre", retired, 0);
    tick();
    check_eq("r_back_fetch", state, 0);
    check_eq("r_retired", retired, 1);

    // lw: 0,1,2,3,4
    op = 6'h23;
    expect_states("lw", 1, 2, 3, 2);
    check_eq("lw_addr_src_b", alu_src_b, 2);
    tick();
    check_eq("lw_rd_state", state, 3);
    check_eq("lw_rd_reg_write", reg_write, 0);
    tick();
    check_eq("lw_wb_state", state, 4);
    check_eq("lw_wb_mem_to_reg", mem_to_reg, 1);
    check_eq("lw_wb_reg_write", reg_write, 1);
    check_eq("lw_retired_pre", retired, 1);
    tick();
    check_eq("lw_retired", retired, 2);

    // sw: 0,1,2,5
    op = 6'h2B;
    expect_states("sw", 1, 2, 5, 2);
    check_eq("sw_addr_mem_write", mem_write, 0);
    tick();
    check_eq("sw_wr_state", state, 5);
    check_eq("sw_mem_write", mem_write, 1);
    check_eq("sw_reg_write", reg_write, 0);
    tick();
    check_eq("sw_fetch", state, 0);
    check_eq("sw_retired", retired, 3);

    // beq with alu_cond 0 and 1
    for (int c = 0; c < 2; c++) begin
      op = 6'h04; alu_cond = c[0];
      expect_states("beq", 1, 8, 0, 2);
      check_eq("beq_alu_op", alu_op, 6'h22);
      check_eq("beq_pc_cond", pc_cond, 1);
      check_eq("beq_pc_source", pc_source, 1);
      tick();
      check_eq("beq_fetch", state, 0);
      check_eq("beq_retired", retired, 4 + c);
    end
    alu_cond = 1'b0;

    // jal
    op = 6'h03;
    expect_states("jal", 1, 12, 0, 2);
    check_eq("jal_pc_write", pc_write, 1);
    check_eq("jal_pc_source", pc_source, 2);
    check_eq("jal_reg_dst", reg_dst, 2);
    check_eq("jal_reg_write", reg_write, 1);
    check_eq("jal_mdr_src", mdr_src, 1);
    check_eq("jal_mem_to_reg", mem_to_reg, 1);
    tick();
    check_eq("jal_retired", retired, 6);

    // j
    op = 6'h02;
    expect_states("j", 1, 9, 0, 2);
    check_eq("j_pc_write", pc_write, 1);
    check_eq("j_pc_source", pc_source, 2);
    check_eq("j_reg_write", reg_write, 0);
    tick();
    check_eq("j_retired", retired, 7);

    // addi: 0,1,10,11
    op = 6'h08;
    expect_states("addi", 1, 10, 11, 3);
    check_eq("addi_reg_write", reg_write, 1);
    check_eq("addi_reg_dst", reg_dst, 0);
    check_eq("addi_mem_to_reg", mem_to_reg, 0);
    tick();
    check_eq("addi_retired", retired, 8);

    // illegal opcode: sticky ERR for 20 cycles, count frozen
    op = 6'h3F;
    expect_states("ill", 1, 15, 15, 2);
    check_eq("ill_error", error, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("ill_hold_state", state, 15);
    end
    check_eq("ill_error_hold", error, 1);
    check_eq("ill_retired", retired, 8);
    check_eq("ill_ir_write", ir_write, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("ill_rst_state", state, 0);
    check_eq("ill_rst_error", error, 0);
    check_eq("ill_rst_retired", retired, 0);

    // alu_err in R_EXE: ERR without a reg_write pulse
    op = 6'h00; func = 6'h22;
    expect_states("aerr", 1, 6, 6, 2);
    check_eq("aerr_alu_op", alu_op, 6'h22);
    alu_err = 1'b1;
    tick();
    alu_err = 1'b0;
    check_eq("aerr_state", state, 15);
    check_eq("aerr_error", error, 1);
    check_eq("aerr_reg_write", reg_write, 0);
    tick();
    check_eq("aerr_hold", state, 15);
    check_eq("aerr_retired", retired, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("aerr_rst_state", state, 0);

    // reset during MEM_WR: write abandoned, no retire
    op = 6'h2B;
    expect_states("swr", 1, 2, 5, 3);
    reset = 1'b1;
    #1;
    check_eq("swr_mem_write_gated", mem_write, 0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("swr_state", state, 0);
    check_eq("swr_retired", retired, 0);

`ifdef MC_CONTROL_MEM_READY_EN
    // lw with mem_ready low for 3 cycles in MEM_RD takes 8 cycles
    op = 6'h23;
    expect_states("lws", 1, 2, 3, 3);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("lws_hold", state, 3);
    end
    mem_ready = 1'b1;
    tick();
    check_eq("lws_wb", state, 4);
    tick();
    check_eq("lws_fetch", state, 0);
    check_eq("lws_retired", retired, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
Moore-style multi-cycle sequencer that drives the MIPS multi-cycle datapath's register enables, mux selects and ALU function, one instruction at a time. It sits beside the PC, IR, register file, ALU and DMem, and takes opcode/func from IR and the ALU condition flag. It also keeps a retired-instruction counter and a sticky error state for unsupported opcodes or ALU faults.

Parameters:
CNT_W, 32, width of retired-instruction counter
ADD_FN, 6'h20, alu_op code for add (address/PC arithmetic)
SUB_FN, 6'h22, alu_op code for subtract (beq compare)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
op  input  6  IR[31:26]
func  input  6  IR[5:0]
alu_cond  input  1  ALU condition flag (equal for SUB)
alu_err  input  1  ALU fault flag
ir_write  output  1  IR load enable
pc_write  output  1  unconditional PC load
pc_cond  output  1  PC load qualified by alu_cond (external AND)
pc_inc  output  1  PC increment by 4
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  0=B, 1=zero, 2=signext, 3=signext<<2
alu_op  output  6  ALU function code
pc_source  output  2  1=ALUOut, 2=jump target {PC[31:28],IR<<2}
mem_write  output  1  DMem write enable
mdr_src  output  1  0=DMem data, 1=PC (link)
reg_write  output  1  register-file write enable
reg_dst  output  2  0=rt, 1=rd, 2=r31
mem_to_reg  output  2  0=ALUOut, 1=MDR
state  output  4  current state, for debug
error  output  1  sticky fault
retired  output  CNT_W  completed-instruction count

Behaviour:
- States (4-bit encoding): FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXE=10, ADDI_WB=11, JAL=12, ERR=15.
- All outputs are decoded from state only. Any output not listed for a state is 0.
- FETCH: ir_write=1, pc_inc=1. Next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD_FN (branch target into ALUOut). Next state by op: 0x00 R_EXE; 0x23/0x2B MEM_ADDR; 0x04 BRANCH; 0x02 JUMP; 0x03 JAL; 0x08 ADDI_EXE; any other value ERR.
- MEM_ADDR: src_a=1, src_b=2, ADD_FN. Next is MEM_RD if op=0x23, otherwise MEM_WR.
- MEM_RD: no enables (DMem read, MDR load). Next is MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Retire, then FETCH.
- MEM_WR: mem_write=1. Retire, then FETCH.
- R_EXE: src_a=1, src_b=0, alu_op=func. Next is R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Retire, then FETCH.
- BRANCH: src_a=1, src_b=0, alu_op=SUB_FN, pc_cond=1, pc_source=1. Retire, then FETCH.
- JUMP: pc_write=1, pc_source=2. Retire, then FETCH.
- JAL: pc_write=1, pc_source=2, mdr_src=1, reg_write=1, reg_dst=2, mem_to_reg=1. Retire, then FETCH.
- ADDI_EXE: src_a=1, src_b=2, ADD_FN. Next is ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Retire, then FETCH.
- Cycles per instruction: lw 5; sw, R-type and addi 4; beq, j and jal 3.
- alu_err is sampled high in R_EXE, ADDI_EXE, MEM_ADDR or BRANCH: next state is ERR. No retire occurs, and the write-back state is never entered.
- ERR: all enables 0, error=1. ERR holds until reset.
- error = (state==ERR).
- retired increments by 1 on the clock edge that leaves a retiring state. It wraps from all-ones to 0 silently.
- Reset mid-instruction: at the reset edge, state=FETCH and retired=0. Write enables are forced 0 in any cycle where reset is high, so a write in flight is abandoned. The first FETCH cycle is the cycle after reset deasserts.

Optional Feature:
MC_CONTROL_MEM_READY_EN adds input mem_ready (1 bit).
- With the macro: FETCH, MEM_RD and MEM_WR hold their state, with their outputs asserted, while mem_ready=0. They advance on the first cycle with mem_ready=1. The retire for MEM_WR occurs only on the advancing edge.
- Without the macro: the port is absent, and these states always take one cycle.

Test Plan:
- Reset, then R-type add (op=0, func=0x20): states 0,1,6,7,0. alu_op=0x20 in state 6. reg_write=1 with reg_dst=1 in state 7. retired=1.
- lw (op=0x23): states 0,1,2,3,4. mem_to_reg=1 in state 4. retired increments once after 5 cycles. Then sw (0x2B): 0,1,2,5. mem_write=1 only in state 5.
- beq (op=0x04): state 8 shows alu_op=0x22, pc_cond=1, pc_source=1, for both alu_cond=0 and alu_cond=1. 3 cycles. retired+1.
- jal (op=0x03): state 12 shows pc_write=1, pc_source=2, reg_dst=2, reg_write=1, mdr_src=1. Then j (0x02): state 9 shows pc_write=1, reg_write=0.
- Illegal op 0x3F: DECODE goes to ERR, error=1 and stays there for 20 cycles. retired unchanged. reset=1 returns state=0, error=0, retired=0. Separately, alu_err=1 in R_EXE gives ERR with no reg_write pulse.
- reset asserted in MEM_WR: mem_write=0 in that cycle, next state is FETCH. With MC_CONTROL_MEM_READY_EN, holding mem_ready=0 for 3 cycles in MEM_RD stretches lw to 8 cycles.
